line_window_gen: RTL



---
 rtl/line_window_gen_if.sv | 24 ++
 rtl/line_window_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/line_window_gen_if.sv
// Pixel-in / window-out handshake bundle for line_window_gen.
// slave = the window generator, master = pixel source plus window consumer.
interface line_window_gen_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] C;
    logic        win_valid;
    logic        win_ready;
    logic        frame_done;

    modport master (
        output pix_in, pix_valid, pix_sof, win_ready,
        input  pix_ready, A, B, C, win_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, pix_sof, win_ready,
        output pix_ready, A, B, C, win_valid, frame_done
    );
endinterface

// File: rtl/line_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus per-row column shifters.
// Optional LINE_WINDOW_WIN_CNT_EN adds a saturating win_cnt window-transfer counter.
module line_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    line_window_gen_if.slave lw
`ifdef LINE_WINDOW_WIN_CNT_EN
    ,
    output logic [31:0]      win_cnt
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [7:0]      lb0 [IMG_W];
    logic [7:0]      lb1 [IMG_W];
    logic [1:0][7:0] top_sr, mid_sr, bot_sr;
    logic [31:0]     a_q, b_q, c_q;
    logic            win_valid_q;
    logic            frame_done_q;

    logic            pix_ready;
    logic            acc;
    logic            restart;
    logic            process;
    logic            last_col;
    logic            win_hit;
    logic [CW-1:0]   col_e;
    logic [RW-1:0]   row_e;
    logic [7:0]      rd0, rd1;

    assign pix_ready = (state != DONE) && (!win_valid_q || lw.win_ready);
    assign acc       = lw.pix_valid && pix_ready;
    assign restart   = acc && lw.pix_sof;
    // A sof pixel always restarts at (0,0); other pixels only count inside a frame.
    assign process   = restart || (acc && (state == FILL || state == RUN));
    assign col_e     = restart ? '0 : col;
    assign row_e     = restart ? '0 : row;
    assign rd0       = lb0[col_e];
    assign rd1       = lb1[col_e];
    assign last_col  = (col_e == COL_LAST);
    assign win_hit   = process && (col_e >= CW'(2)) && (row_e >= RW'(2));

    assign lw.pix_ready  = pix_ready;
    assign lw.A          = a_q;
    assign lw.B          = b_q;
    assign lw.C          = c_q;
    assign lw.win_valid  = win_valid_q;
    assign lw.frame_done = frame_done_q;

    // Line storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (process) begin
            lb1[col_e] <= rd0;
            lb0[col_e] <= lw.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            top_sr       <= '0;
            mid_sr       <= '0;
            bot_sr       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (process) begin
                top_sr <= {top_sr[0], rd1};
                mid_sr <= {mid_sr[0], rd0};
                bot_sr <= {bot_sr[0], lw.pix_in};
                if (last_col) begin
                    col <= '0;
                    row <= (row_e == ROW_LAST) ? '0 : row_e + 1'b1;
                end else begin
                    col <= col_e + 1'b1;
                    row <= row_e;
                end
            end

            // A fresh window overrides a concurrent transfer, keeping 1 pixel/clk.
            if (win_hit) begin
                a_q         <= {8'h00, top_sr[1], top_sr[0], rd1};
                b_q         <= {8'h00, mid_sr[1], mid_sr[0], rd0};
                c_q         <= {8'h00, bot_sr[1], bot_sr[0], lw.pix_in};
                win_valid_q <= 1'b1;
            end else if (lw.win_ready) begin
                win_valid_q <= 1'b0;
            end

            case (state)
                IDLE: if (restart) state <= FILL;
                FILL: begin
                    if (restart)
                        state <= FILL;
                    else if (acc && last_col && row == RW'(1))
                        state <= RUN;
                end
                RUN: begin
                    if (restart)
                        state <= FILL;
                    else if (acc && last_col && row == ROW_LAST)
                        state <= DONE;
                end
                DONE: begin
                    if (!win_valid_q) begin
                        frame_done_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_WINDOW_WIN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || restart)
            win_cnt <= '0;
        else if (win_valid_q && lw.win_ready && win_cnt != 32'hFFFF_FFFF)
            win_cnt <= win_cnt + 32'd1;
    end
`endif

endmodule
